// File: rtl/parallel_in.sv
// Parallel-in/parallel-out register: captures a on every rising edge and
// presents it on q one cycle later; synchronous active-high reset loads RST_VAL.
module parallel_in #(
    parameter int unsigned     n       = 3,
    parameter logic [n-1:0]    RST_VAL = {n{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] a,
    output logic [n-1:0] q
);

    logic [n-1:0] q_r;

    // No enable: every non-reset edge loads a new word.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= RST_VAL;
        end else begin
            q_r <= a;
        end
    end

    assign q = q_r;

endmodule

// File: tb/tb_parallel_in.sv
// Randomized bench for parallel_in at n=3 (default), n=1 and n=8 with RST_VAL=8'hA5.
module tb_parallel_in;

    logic       clk;
    logic       rst;
    logic [2:0] a3;
    logic [2:0] q3;
    logic       a1;
    logic       q1;
    logic [7:0] a8;
    logic [7:0] q8;

    int checks;
    int errors;

    parallel_in dut3 (
        .clk (clk),
        .rst (rst),
        .a   (a3),
        .q   (q3)
    );

    parallel_in #(.n(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .a   (a1),
        .q   (q1)
    );

    parallel_in #(.n(8), .RST_VAL(8'hA5)) dut8 (
        .clk (clk),
        .rst (rst),
        .a   (a8),
        .q   (q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference: after an edge, q is RST_VAL if rst was high before the edge, else the prior a.
    logic [2:0] m3;
    logic       m1;
    logic [7:0] m8;

    // Drive inputs at the falling edge, then check after the next rising edge,
    // then disturb a and rst between edges and confirm q holds.
    task automatic cycle(input logic r, input logic [2:0] v3, input logic v1, input logic [7:0] v8,
                         input string tag);
        @(negedge clk);
        rst = r;
        a3  = v3;
        a1  = v1;
        a8  = v8;
        m3  = r ? 3'b000 : v3;
        m1  = r ? 1'b0   : v1;
        m8  = r ? 8'hA5  : v8;
        @(posedge clk);
        #1;
        check({tag, "_q3"}, 8'(q3), 8'(m3));
        check({tag, "_q1"}, 8'(q1), 8'(m1));
        check({tag, "_q8"}, q8, m8);
        #2;
        a3  = ~v3;
        a1  = ~v1;
        a8  = ~v8;
        rst = ~r;
        #1;
        check({tag, "_hold3"}, 8'(q3), 8'(m3));
        check({tag, "_hold8"}, q8, m8);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset across the first edge with nonzero data present.
        rst = 1'b1;
        a3  = 3'b100;
        a1  = 1'b1;
        a8  = 8'hFF;
        @(posedge clk);
        #1;
        check("reset_q3", 8'(q3), 8'h00);
        check("reset_q1", 8'(q1), 8'h00);
        check("reset_q8", q8, 8'hA5);

        cycle(1'b0, 3'b001, 1'b1, 8'h3C, "first_load");

        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 3'($urandom), 1'($urandom), 8'($urandom), "random");
        end

        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 3'b111, 1'b1, 8'hFF, "hold111");
        end

        cycle(1'b0, 3'b101, 1'b0, 8'h5A, "pre_reset");
        cycle(1'b1, 3'b110, 1'b1, 8'h3C, "mid_reset");
        cycle(1'b0, 3'b110, 1'b1, 8'h3C, "resume");

        for (int i = 0; i < 10; i++) begin
            cycle(1'($urandom_range(0, 3) == 0), 3'($urandom), 1'($urandom), 8'($urandom), "mixed");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
